rx_parity_accumulator: RTL and testbench

Serial, parametrised parity engine for the USART receive path. It accumulates parity bit-by-bit as the receive shift logic delivers data bits, LSB first. It then samples the received parity bit and reports a per-frame parity error with a completion pulse. A saturating error counter is included for status. It replaces whole-frame combinational parity evaluation and supports data widths from 1 to MAX_DATA_BITS.

---
 rtl/rx_parity_accumulator.sv | 154 +++++++++++++++
 tb/tb_rx_parity_accumulator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_parity_accumulator.sv
// rtl/rx_parity_accumulator.sv - serial bit-by-bit parity accumulator for the USART receive path
module rx_parity_accumulator #(
    parameter int MAX_DATA_BITS = 9,
    parameter int BITS_W        = 4,
    parameter int CNT_W         = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [BITS_W-1:0] i_data_bits,
    input  logic              i_parity_en,
    input  logic              i_parity_odd,
    input  logic              i_bit_valid,
    input  logic              i_bit,
    input  logic              i_err_clr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_parity_err,
    output logic              o_parity_calc,
    output logic [CNT_W-1:0]  o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    localparam logic [BITS_W-1:0] MAX_BITS = BITS_W'(MAX_DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [BITS_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BITS_W-1:0] n_q, n_d;
    logic              acc_q, acc_d;
    logic              odd_q, odd_d;
    logic              par_en_q, par_en_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [BITS_W-1:0] n_eff;
    logic [BITS_W-1:0] bit_cnt_inc;
    logic              frame_err;
    logic              cnt_inc;

    // Clamp the requested width into 1..MAX_DATA_BITS before latching it
    always_comb begin
        n_eff = i_data_bits;
        if (i_data_bits == '0) begin
            n_eff = BITS_W'(1);
        end else if (i_data_bits > MAX_BITS) begin
            n_eff = MAX_BITS;
        end
    end

    // Frame sequencing: start latches config, data bits fold into the accumulator, parity bit is judged
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        n_d         = n_q;
        acc_d       = acc_q;
        odd_d       = odd_q;
        par_en_d    = par_en_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        frame_err   = 1'b0;
        cnt_inc     = 1'b0;
        bit_cnt_inc = bit_cnt_q + BITS_W'(1);

        if (i_start) begin
            // A start always wins, aborting any frame in flight and dropping a same-cycle bit
            n_d       = n_eff;
            par_en_d  = i_parity_en;
            odd_d     = i_parity_odd;
            acc_d     = 1'b0;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
            state_d   = S_DATA;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (i_bit_valid) begin
                        acc_d     = acc_q ^ i_bit;
                        bit_cnt_d = bit_cnt_inc;
                        if (bit_cnt_inc == n_q) begin
                            if (par_en_q) begin
                                state_d = S_PARITY;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                perr_d  = 1'b0;
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (i_bit_valid) begin
                        frame_err = acc_q ^ odd_q ^ i_bit;
                        perr_d    = frame_err;
                        done_d    = 1'b1;
                        cnt_inc   = frame_err;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    // Idle: stray bits are ignored and the accumulator holds
                end
            endcase
        end
    end

    // Saturating error counter; a clear overrides a coincident increment
    always_comb begin
        cnt_d = cnt_q;
        if (i_err_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            n_q       <= BITS_W'(1);
            acc_q     <= 1'b0;
            odd_q     <= 1'b0;
            par_en_q  <= 1'b0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            odd_q     <= odd_d;
            par_en_q  <= par_en_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;
    assign o_parity_err  = perr_q;
    assign o_parity_calc = acc_q ^ odd_q;
    assign o_err_cnt     = cnt_q;

endmodule

// File: tb/tb_rx_parity_accumulator.sv
// tb/tb_rx_parity_accumulator.sv - self-checking bench for rx_parity_accumulator
module tb_rx_parity_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] data_bits = 4'd0;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       err_clr = 1'b0;

    logic       busy, done, perr, calc;
    logic [7:0] cnt8;
    logic       busy_s, done_s, perr_s, calc_s;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    rx_parity_accumulator dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_data_bits(data_bits),
        .i_parity_en(par_en), .i_parity_odd(par_odd), .i_bit_valid(bit_valid),
        .i_bit(bit_in), .i_err_clr(err_clr), .o_busy(busy), .o_done(done),
        .o_parity_err(perr), .o_parity_calc(calc), .o_err_cnt(cnt8)
    );

    rx_parity_accumulator #(.CNT_W(2)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_data_bits(data_bits),
        .i_parity_en(par_en), .i_parity_odd(par_odd), .i_bit_valid(bit_valid),
        .i_bit(bit_in), .i_err_clr(err_clr), .o_busy(busy_s), .o_done(done_s),
        .o_parity_err(perr_s), .o_parity_calc(calc_s), .o_err_cnt(cnt2)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a list of received bits judged as a whole
    int   m_phase = 0;
    int   m_n = 1;
    bit   m_pen = 0;
    bit   m_odd = 0;
    bit   m_bits[$];
    bit   m_done = 0;
    bit   m_perr = 0;
    int   m_cnt8 = 0;
    int   m_cnt2 = 0;

    function automatic bit xor_list();
        bit r = 0;
        foreach (m_bits[i]) r = r ^ m_bits[i];
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_pen = 0; m_odd = 0; m_bits.delete();
                m_done = 0; m_perr = 0; m_cnt8 = 0; m_cnt2 = 0;
            end else begin
                bit inc;
                inc = 0;
                m_done = 0;
                if (start) begin
                    m_bits.delete();
                    m_odd = par_odd;
                    m_pen = par_en;
                    m_n = (data_bits == 0) ? 1 : ((data_bits > 9) ? 9 : int'(data_bits));
                    m_perr = 0;
                    m_phase = 1;
                end else if (m_phase == 1 && bit_valid) begin
                    m_bits.push_back(bit_in);
                    if (m_bits.size() == m_n) begin
                        if (m_pen) m_phase = 2;
                        else begin
                            m_phase = 0; m_done = 1; m_perr = 0;
                        end
                    end
                end else if (m_phase == 2 && bit_valid) begin
                    m_perr = xor_list() ^ m_odd ^ bit_in;
                    m_done = 1;
                    m_phase = 0;
                    inc = m_perr;
                end
                if (err_clr) begin
                    m_cnt8 = 0; m_cnt2 = 0;
                end else if (inc) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        automatic bit exp_calc = xor_list() ^ m_odd;
        check("busy", int'(busy), int'(m_phase != 0));
        check("done", int'(done), int'(m_done));
        check("perr", int'(perr), int'(m_perr));
        check("calc", int'(calc), int'(exp_calc));
        check("cnt8", int'(cnt8), m_cnt8);
        check("busy_s", int'(busy_s), int'(m_phase != 0));
        check("done_s", int'(done_s), int'(m_done));
        check("calc_s", int'(calc_s), int'(exp_calc));
        check("perr_s", int'(perr_s), int'(m_perr));
        check("cnt2", int'(cnt2), m_cnt2);
        if (done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input int nb, input bit en, input bit odd);
        start = 1'b1; data_bits = 4'(nb); par_en = en; par_odd = odd;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        bit_valid = 1'b1; bit_in = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_data(input logic [8:0] d, input int count);
        for (int i = 0; i < count; i++) send_bit(d[i]);
    endtask

    initial begin
        int d0;
        int c0;
        bit calc0;
        tick();
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_calc", int'(calc), 0);
        check("reset_cnt", int'(cnt8), 0);
        rst = 1'b0;
        tick();

        // Reset mid-frame
        d0 = done_seen;
        start_frame(8, 1, 1);
        send_data(9'h007, 3);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_calc", int'(calc), 0);
        check("midrst_done", int'(done), 0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_no_done", done_seen, d0);
        start_frame(8, 1, 0);
        send_data(9'h0A5, 8);
        send_bit(1'b0);
        check("post_rst_done", int'(done), 1);
        check("post_rst_perr", int'(perr), 0);

        // Even parity, n=8, 0xA5
        tick();
        start_frame(8, 1, 0);
        send_data(9'h0A5, 8);
        check("a5_calc", int'(calc), 0);
        send_bit(1'b0);
        check("a5_done", int'(done), 1);
        check("a5_perr", int'(perr), 0);
        check("a5_busy", int'(busy), 0);
        check("a5_cnt", int'(cnt8), 0);
        tick();
        check("a5_done_1cyc", int'(done), 0);
        start_frame(8, 1, 0);
        send_data(9'h0A5, 8);
        send_bit(1'b1);
        check("a5e_done", int'(done), 1);
        check("a5e_perr", int'(perr), 1);
        check("a5e_cnt", int'(cnt8), 1);

        // Back-to-back: start in the cycle done is high; odd parity n=9, 0x1FF
        start_frame(9, 1, 1);
        check("b2b_perr_cleared", int'(perr), 0);
        send_data(9'h1FF, 9);
        send_bit(1'b0);
        check("ff_perr", int'(perr), 0);
        check("ff_cnt", int'(cnt8), 1);

        // Odd parity, n=5, 5'b10110
        start_frame(5, 1, 1);
        send_data(9'h016, 5);
        check("n5_calc", int'(calc), 0);
        send_bit(1'b0);
        check("n5_perr", int'(perr), 0);

        // Parity disabled, n=7
        start_frame(7, 0, 0);
        send_data(9'h05B, 6);
        check("np_busy6", int'(busy), 1);
        send_bit(1'b1);
        check("np_done", int'(done), 1);
        check("np_perr", int'(perr), 0);

        // Clamp: 0 -> 1 bit, 15 -> 9 bits
        tick();
        start_frame(0, 0, 0);
        send_bit(1'b1);
        check("clamp0_done", int'(done), 1);
        tick();
        start_frame(15, 0, 0);
        send_data(9'h155, 8);
        check("clamp15_busy8", int'(busy), 1);
        send_bit(1'b1);
        check("clamp15_done", int'(done), 1);

        // Start with coincident bit: bit discarded
        tick();
        start = 1'b1; data_bits = 4'd1; par_en = 1'b0; par_odd = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0;
        check("start_drop_calc", int'(calc), 0);
        check("start_drop_busy", int'(busy), 1);
        send_bit(1'b0);

        // Abort and restart
        tick();
        d0 = done_seen; c0 = int'(cnt8);
        start_frame(8, 1, 0);
        send_data(9'h0FF, 4);
        start_frame(8, 1, 0);
        send_data(9'h0A5, 8);
        send_bit(1'b1);
        tick();
        check("abort_one_done", done_seen - d0, 1);
        check("abort_cnt", int'(cnt8), c0 + 1);

        // Stray bits in IDLE
        calc0 = calc;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("idle_calc", int'(calc), int'(calc0));
        check("idle_busy", int'(busy), 0);

        // Saturation on the narrow counter, then clear coincident with an error
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_cnt2", int'(cnt2), 0);
        for (int k = 0; k < 4; k++) begin
            start_frame(2, 1, 0);
            send_data(9'h001, 2);
            send_bit(1'b0);
        end
        check("sat_cnt2", int'(cnt2), 3);
        check("sat_cnt8", int'(cnt8), 4);
        start_frame(2, 1, 0);
        send_data(9'h001, 2);
        err_clr = 1'b1;
        send_bit(1'b0);
        err_clr = 1'b0;
        check("clr_win_cnt2", int'(cnt2), 0);
        check("clr_win_cnt8", int'(cnt8), 0);
        check("clr_win_perr", int'(perr), 1);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
